viterbi_traceback_ctrl: RTL and testbench

- Frame-level sequencer for the 4-state (K=3, rate-1/2) Viterbi decoder.
- Clears the path-metric registers and paces the ACS stage one trellis step per accepted symbol, storing each step's 4 survivor decisions.
- After the last step, serially searches the four path metrics for the best end state (lowest metric, lower index wins ties), traces back through survivor memory, and emits decoded bits in forward order over a valid/ready handshake.

---
 rtl/viterbi_traceback_ctrl.sv | 156 +++++++++++++++
 tb/tb_viterbi_traceback_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback_ctrl.sv
// Frame sequencer for a 4-state Viterbi decoder: clears and paces the ACS,
// stores survivors, picks the best end state, traces back and streams bits out.
module viterbi_traceback_ctrl #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7,
    parameter int PM_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic [3:0]       surv,
    input  logic [PM_W-1:0]  pm0,
    input  logic [PM_W-1:0]  pm1,
    input  logic [PM_W-1:0]  pm2,
    input  logic [PM_W-1:0]  pm3,
    output logic             pm_clear,
    output logic             acs_en,
    output logic [1:0]       best_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, ACQ, SEARCH, TRACE, EMIT} state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [1:0]       i;
    logic [1:0]       idx;
    logic [1:0]       tstate;
    logic [PM_W-1:0]  min_pm;
    logic [PM_W-1:0]  pm_sel;
    logic [1:0]       search_best;
    logic [AW-1:0]    addr;
    logic             d;

    logic [3:0] surv_mem [MAX_LEN];
    logic       dbuf     [MAX_LEN];

    always_comb begin
        pm_sel = pm0;
        case (i)
            2'd1: pm_sel = pm1;
            2'd2: pm_sel = pm2;
            2'd3: pm_sel = pm3;
            default: pm_sel = pm0;
        endcase
    end

    // Strict compare keeps the lower index on ties.
    assign search_best = (pm_sel < min_pm) ? i : idx;

    // cnt is the step address in ACQ, trace address in TRACE, bit index in EMIT.
    assign addr     = cnt[AW-1:0];
    assign d        = surv_mem[addr][tstate];
    assign acs_en   = step_valid & step_ready;
    assign out_bit  = out_valid & dbuf[addr];
    assign out_last = out_valid & (cnt == len - 1'b1);

    always_ff @(posedge clk) begin
        if (acs_en)
            surv_mem[addr] <= surv;
        if (state == TRACE)
            dbuf[addr] <= tstate[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            cnt        <= '0;
            i          <= '0;
            idx        <= '0;
            tstate     <= '0;
            min_pm     <= '0;
            best_state <= '0;
            step_ready <= 1'b0;
            pm_clear   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && frame_len != '0) begin
                        len      <= (frame_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : frame_len;
                        pm_clear <= 1'b1;
                        busy     <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    pm_clear   <= 1'b0;
                    step_ready <= 1'b1;
                    cnt        <= '0;
                    state      <= ACQ;
                end
                ACQ: begin
                    if (acs_en) begin
                        if (cnt == len - 1'b1) begin
                            step_ready <= 1'b0;
                            i          <= '0;
                            state      <= SEARCH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    i <= i + 1'b1;
                    if (i == 2'd0) begin
                        min_pm <= pm_sel;
                        idx    <= 2'd0;
                    end else begin
                        min_pm <= (pm_sel < min_pm) ? pm_sel : min_pm;
                        idx    <= search_best;
                    end
                    if (i == 2'd3) begin
                        best_state <= search_best;
                        tstate     <= search_best;
                        cnt        <= len - 1'b1;
                        state      <= TRACE;
                    end
                end
                TRACE: begin
                    tstate <= {tstate[0], d};
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (cnt == len - 1'b1) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_viterbi_traceback_ctrl.sv
// Scoreboard bench for viterbi_traceback_ctrl: expected bits are queued when a
// frame is driven and popped as the decoder hands bits out.
module tb_viterbi_traceback_ctrl;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;
    localparam int PM_W    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             step_valid = 1'b0;
    logic             step_ready;
    logic [3:0]       surv = '0;
    logic [PM_W-1:0]  pm0 = '0, pm1 = '0, pm2 = '0, pm3 = '0;
    logic             pm_clear, acs_en;
    logic [1:0]       best_state;
    logic             out_valid, out_bit, out_last, busy;
    logic             out_ready = 1'b0;

    viterbi_traceback_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .PM_W(PM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .step_valid(step_valid), .step_ready(step_ready), .surv(surv),
        .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
        .pm_clear(pm_clear), .acs_en(acs_en), .best_state(best_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acs_cnt = 0;
    int clr_cnt = 0;
    bit exp_q[$];
    bit mon_e;
    logic [3:0] sv_tab [MAX_LEN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Handshakes are resolved at the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (acs_en) acs_cnt++;
        if (pm_clear) clr_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_bit", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_bit", out_bit, mon_e);
                check("out_last", out_last, exp_q.size() == 0);
            end
        end
    end

    task automatic set_pm(input int a, input int b, input int c, input int e);
        pm0 = PM_W'(a); pm1 = PM_W'(b); pm2 = PM_W'(c); pm3 = PM_W'(e);
    endtask

    task automatic run_frame(input int flen, input int exp_best, input bit gaps,
                             input int stall_j, input bit poke_start);
        int n, k, cyc, waited, stall;
        logic [1:0] st;
        logic dd;
        bit bits[MAX_LEN];
        n = (flen > MAX_LEN) ? MAX_LEN : flen;
        st = exp_best[1:0];
        for (int a = n - 1; a >= 0; a--) begin
            bits[a] = st[1];
            dd = sv_tab[a][st];
            st = {st[0], dd};
        end
        for (int x = 0; x < n; x++) exp_q.push_back(bits[x]);
        acs_cnt = 0;
        clr_cnt = 0;

        start = 1'b1; frame_len = LEN_W'(flen);
        @(posedge clk); #1;
        start = 1'b0;
        check("clear_pulse", pm_clear, 1);
        @(posedge clk); #1;
        check("ready_latency", step_ready, 1);

        k = 0; cyc = 0;
        while (k < n && cyc < 2000) begin
            if (gaps && (cyc % 3 == 1)) step_valid = 1'b0;
            else begin step_valid = 1'b1; surv = sv_tab[k]; end
            if (step_valid && step_ready) k++;
            @(posedge clk); #1;
            cyc++;
        end
        step_valid = 1'b0; surv = '0;
        check("acq_steps", k, n);

        waited = 0;
        while (!out_valid && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        check("out_latency", waited + 1, n + 5);
        check("best_state", best_state, exp_best);

        cyc = 0; stall = 0;
        while (busy && cyc < 500) begin
            if (stall_j >= 0 && (n - exp_q.size()) == stall_j && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else out_ready = 1'b1;
            start = poke_start && (cyc == 2);
            if (!out_ready) begin
                check("hold_bit", out_bit, exp_q[0]);
                check("hold_last", out_last, exp_q.size() == 1);
                check("hold_valid", out_valid, 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0; start = 1'b0;
        check("busy_end", busy, 0);
        check("valid_end", out_valid, 0);
        check("queue_empty", exp_q.size(), 0);
        check("acs_count", acs_cnt, n);
        check("clear_count", clr_cnt, 1);
        if (stall_j >= 0) check("stall_cycles", stall, 3);
        @(posedge clk); #1;
        check("stay_idle", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", step_ready, 0);
        check("rst_clear", pm_clear, 0);
        check("rst_acs", acs_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_bit", out_bit, 0);
        check("rst_last", out_last, 0);
        check("rst_best", best_state, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-zero survivors, state 0 clearly best.
        for (int x = 0; x < 4; x++) sv_tab[x] = 4'b0000;
        set_pm(0, 5, 5, 5);
        run_frame(4, 0, 1'b0, -1, 1'b0);

        // Decoded 1,0,1,1 from best end state 3.
        sv_tab[2] = 4'b0100;
        set_pm(9, 7, 8, 2);
        run_frame(4, 3, 1'b0, -1, 1'b0);

        // Same frame with input gaps, output stall at j=1 and a stray start in EMIT.
        run_frame(4, 3, 1'b1, 1, 1'b1);

        for (int x = 0; x < 4; x++) sv_tab[x] = 4'b0000;
        set_pm(5, 5, 5, 5);
        run_frame(4, 0, 1'b0, -1, 1'b0);
        set_pm(6, 3, 3, 4);
        run_frame(4, 1, 1'b0, -1, 1'b0);

        clr_cnt = 0;
        start = 1'b1; frame_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_busy", busy, 0);
        @(posedge clk); #1;
        check("len0_busy2", busy, 0);
        check("len0_clear", clr_cnt, 0);

        for (int x = 0; x < MAX_LEN; x++) sv_tab[x] = 4'($urandom_range(0, 15));
        set_pm(3, 1, 2, 1);
        run_frame(100, 1, 1'b0, -1, 1'b0);

        // Abort mid-acquisition after two accepts.
        acs_cnt = 0;
        start = 1'b1; frame_len = 7'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        step_valid = 1'b1; surv = 4'b1010;
        repeat (2) @(posedge clk);
        #1;
        step_valid = 1'b0;
        check("abort_accepts", acs_cnt, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", step_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_best", best_state, 0);
        check("abort_valid", out_valid, 0);

        sv_tab[0] = 4'b0110; sv_tab[1] = 4'b1001;
        set_pm(4, 4, 0, 0);
        run_frame(2, 2, 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
